// File: rtl/median_result_collector.sv
// -----------------------------------------------------------------------------
// median_result_collector
//
// Purpose:
//   Downstream stage of simpleMedianTop. Stores the filtered binary frame
//   produced by the median stage in an IMG_WIDTH x IMG_HEIGHT bit store. It
//   counts the set pixels and, optionally, tracks their bounding box. At end of
//   frame it offers a summary through a valid/ready handshake. The frame stays
//   readable until the summary is accepted. The store is then wiped one column
//   per cycle before the next frame is collected.
//
// Optional feature:
//   MEDIAN_BBOX_EN - when defined, xMin/xMax/yMin/yMax track the bounding box
//                    of every in-range data=1 write. When undefined, those
//                    outputs are constant 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   writeMedianMem        write strobe from the median stage
//   writeMedianData       pixel value to store
//   xAddressOutMedianMem  write column
//   yAddressOutMedianMem  write row
//   fullImageDone         one-cycle end-of-frame pulse
//   readX, readY          readout address; readData follows one cycle later
//   readData              stored pixel (0 for out-of-range addresses)
//   summaryValid          frame summary available
//   summaryReady          consumer accepts the summary
//   activeCount           number of set pixels in the frame
//   xMin/xMax/yMin/yMax   bounding box of set pixels
//   busy                  high while the store is being cleared
//   overrun               sticky flag: a write was dropped; cleared on accept
// -----------------------------------------------------------------------------
module median_result_collector #(
  parameter int IMG_WIDTH  = 240,
  parameter int IMG_HEIGHT = 180,
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeMedianMem,
  input  logic              writeMedianData,
  input  logic [ADDR_W-1:0] xAddressOutMedianMem,
  input  logic [ADDR_W-1:0] yAddressOutMedianMem,
  input  logic              fullImageDone,
  input  logic [ADDR_W-1:0] readX,
  input  logic [ADDR_W-1:0] readY,
  output logic              readData,
  output logic              summaryValid,
  input  logic              summaryReady,
  output logic [CNT_W-1:0]  activeCount,
  output logic [ADDR_W-1:0] xMin,
  output logic [ADDR_W-1:0] xMax,
  output logic [ADDR_W-1:0] yMin,
  output logic [ADDR_W-1:0] yMax,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] X_LIM    = ADDR_W'(IMG_WIDTH);
  localparam logic [ADDR_W-1:0] Y_LIM    = ADDR_W'(IMG_HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t stateReg, stateNext;
  logic [ADDR_W-1:0] clrColReg;
  logic [CNT_W-1:0]  activeCountReg;
  logic              overrunReg;
  logic              readDataReg;

  // One word per column so that a whole column can be wiped in one cycle.
  logic [IMG_HEIGHT-1:0] mem [IMG_WIDTH];

  logic wrInRange;
  logic wrAccept;
  logic rdInRange;
  logic oldBit;
  logic accept;

  assign wrInRange = (xAddressOutMedianMem < X_LIM) && (yAddressOutMedianMem < Y_LIM);
  assign wrAccept  = writeMedianMem && wrInRange && (stateReg == COLLECT);
  assign rdInRange = (readX < X_LIM) && (readY < Y_LIM);
  // Previous value of the target pixel. It is only used when wrAccept is set,
  // so the address is in range whenever it matters.
  assign oldBit    = mem[xAddressOutMedianMem][yAddressOutMedianMem];
  assign accept    = summaryValid && summaryReady;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg  <= CLEAR;
      clrColReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == CLEAR && clrColReg != LAST_COL)
        clrColReg <= clrColReg + ADDR_W'(1);
      else
        clrColReg <= '0;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    busy         = 1'b0;
    summaryValid = 1'b0;
    case (stateReg)
      CLEAR: begin
        busy = 1'b1;
        if (clrColReg == LAST_COL)
          stateNext = COLLECT;
      end
      COLLECT: begin
        // A write in the same cycle is still applied by wrAccept.
        if (fullImageDone)
          stateNext = REPORT;
      end
      REPORT: begin
        summaryValid = 1'b1;
        if (summaryReady)
          stateNext = CLEAR;
      end
      default: stateNext = CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bit store: clear sweep, pixel writes and registered readout
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (stateReg == CLEAR)
        mem[clrColReg] <= '0;
      else if (wrAccept)
        mem[xAddressOutMedianMem][yAddressOutMedianMem] <= writeMedianData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      readDataReg <= 1'b0;
    else
      readDataReg <= rdInRange ? mem[readX][readY] : 1'b0;
  end

  assign readData = readDataReg;

  // ---------------------------------------------------------------------------
  // Active-pixel counter and overrun flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || stateReg == CLEAR) begin
      activeCountReg <= '0;
    end else if (wrAccept) begin
      // Only real 0->1 or 1->0 transitions move the count. The count therefore
      // stays between 0 and the pixel total and never wraps.
      if (writeMedianData && !oldBit)
        activeCountReg <= activeCountReg + CNT_W'(1);
      else if (!writeMedianData && oldBit)
        activeCountReg <= activeCountReg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrunReg <= 1'b0;
    end else begin
      if (accept)
        overrunReg <= 1'b0;
      // A write dropped in the acceptance cycle is still flagged for the next frame.
      if (writeMedianMem && !wrAccept)
        overrunReg <= 1'b1;
    end
  end

  assign activeCount = activeCountReg;
  assign overrun     = overrunReg;

  // ---------------------------------------------------------------------------
  // Bounding box
  // ---------------------------------------------------------------------------
`ifdef MEDIAN_BBOX_EN
  logic [ADDR_W-1:0] xMinReg, xMaxReg, yMinReg, yMaxReg;

  // The box only grows. Clearing a pixel never shrinks it.
  always_ff @(posedge clk) begin
    if (reset || stateReg == CLEAR) begin
      xMinReg <= '1;
      xMaxReg <= '0;
      yMinReg <= '1;
      yMaxReg <= '0;
    end else if (wrAccept && writeMedianData) begin
      if (xAddressOutMedianMem < xMinReg) xMinReg <= xAddressOutMedianMem;
      if (xAddressOutMedianMem > xMaxReg) xMaxReg <= xAddressOutMedianMem;
      if (yAddressOutMedianMem < yMinReg) yMinReg <= yAddressOutMedianMem;
      if (yAddressOutMedianMem > yMaxReg) yMaxReg <= yAddressOutMedianMem;
    end
  end

  assign xMin = xMinReg;
  assign xMax = xMaxReg;
  assign yMin = yMinReg;
  assign yMax = yMaxReg;
`else
  assign xMin = '0;
  assign xMax = '0;
  assign yMin = '0;
  assign yMax = '0;
`endif

endmodule

// File: tb/tb_median_result_collector.sv
// -----------------------------------------------------------------------------
// tb_median_result_collector
//
// Purpose:
//   Self-checking bench for median_result_collector. It covers the reset state,
//   the clear timing and a table of writes with their expected counts. It runs
//   the report hold/accept handshake, dropped writes, an end-of-frame pulse that
//   coincides with a write, a mid-frame reset, and randomized writes and reads.
//   Expected values come from a frame-level model: a bit array, a popcount and a
//   running min/max of the set-pixel writes.
//   Define MEDIAN_BBOX_EN for both the bench and the DUT to check the bounding box.
// -----------------------------------------------------------------------------
module tb_median_result_collector;

  localparam int W = 240;
  localparam int H = 180;

  logic        clk = 1'b0;
  logic        reset;
  logic        writeMedianMem;
  logic        writeMedianData;
  logic [7:0]  xAddressOutMedianMem;
  logic [7:0]  yAddressOutMedianMem;
  logic        fullImageDone;
  logic [7:0]  readX;
  logic [7:0]  readY;
  logic        readData;
  logic        summaryValid;
  logic        summaryReady;
  logic [15:0] activeCount;
  logic [7:0]  xMin, xMax, yMin, yMax;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  median_result_collector dut (
    .clk                  (clk),
    .reset                (reset),
    .writeMedianMem       (writeMedianMem),
    .writeMedianData      (writeMedianData),
    .xAddressOutMedianMem (xAddressOutMedianMem),
    .yAddressOutMedianMem (yAddressOutMedianMem),
    .fullImageDone        (fullImageDone),
    .readX                (readX),
    .readY                (readY),
    .readData             (readData),
    .summaryValid         (summaryValid),
    .summaryReady         (summaryReady),
    .activeCount          (activeCount),
    .xMin                 (xMin),
    .xMax                 (xMax),
    .yMin                 (yMin),
    .yMax                 (yMax),
    .busy                 (busy),
    .overrun              (overrun)
  );

  int passCnt  = 0;
  int totalCnt = 0;

  // Frame-level reference: pixel array plus the box of all data=1 writes.
  bit refMem [W][H];
  int refXMin, refXMax, refYMin, refYMax;

  typedef struct {
    int x;
    int y;
    bit d;
    int expCount;
  } wr_vec_t;

  wr_vec_t vecs [4] = '{
    '{10, 20, 1'b1, 1},
    '{10, 20, 1'b1, 1},
    '{11, 21, 1'b1, 2},
    '{10, 20, 1'b0, 1}
  };

  task automatic chk(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp)
      passCnt++;
    else
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int refCount();
    int n = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++)
        n += int'(refMem[i][j]);
    return n;
  endfunction

  task automatic modelClear();
    foreach (refMem[i, j]) refMem[i][j] = 1'b0;
    refXMin = 255; refXMax = 0; refYMin = 255; refYMax = 0;
  endtask

  task automatic modelWrite(input int x, input int y, input bit d);
    if (x < W && y < H) begin
      refMem[x][y] = d;
      if (d) begin
        if (x < refXMin) refXMin = x;
        if (x > refXMax) refXMax = x;
        if (y < refYMin) refYMin = y;
        if (y > refYMax) refYMax = y;
      end
    end
  endtask

  task automatic checkBox(input string tag);
`ifdef MEDIAN_BBOX_EN
    chk({tag, "_xMin"}, int'(xMin), refXMin);
    chk({tag, "_xMax"}, int'(xMax), refXMax);
    chk({tag, "_yMin"}, int'(yMin), refYMin);
    chk({tag, "_yMax"}, int'(yMax), refYMax);
`else
    chk({tag, "_xMin"}, int'(xMin), 0);
    chk({tag, "_xMax"}, int'(xMax), 0);
    chk({tag, "_yMin"}, int'(yMin), 0);
    chk({tag, "_yMax"}, int'(yMax), 0);
`endif
  endtask

  // One write cycle, driven at a falling edge; returns at the next falling edge.
  task automatic drive(input int x, input int y, input bit d, input bit fid);
    writeMedianMem       = 1'b1;
    writeMedianData      = d;
    xAddressOutMedianMem = 8'(x);
    yAddressOutMedianMem = 8'(y);
    fullImageDone        = fid;
    @(negedge clk);
    writeMedianMem = 1'b0;
    fullImageDone  = 1'b0;
    $display("write x=%0d y=%0d d=%0d done=%0d -> count=%0d valid=%0d overrun=%0d",
             x, y, d, fid, activeCount, summaryValid, overrun);
  endtask

  // Called on the first falling edge with busy high. Counts the busy cycles.
  // It can optionally inject a write or an end-of-frame pulse mid-clear.
  task automatic waitClear(input string tag, input bit wrDuring, input bit fidDuring);
    int cnt = 0;
    bit sawValid = 1'b0;
    while (busy && cnt < 1000) begin
      if (summaryValid) sawValid = 1'b1;
      cnt++;
      writeMedianMem       = wrDuring && (cnt == 10);
      writeMedianData      = 1'b1;
      xAddressOutMedianMem = 8'd0;
      yAddressOutMedianMem = 8'd0;
      fullImageDone        = fidDuring && (cnt == 20);
      @(negedge clk);
    end
    writeMedianMem = 1'b0;
    fullImageDone  = 1'b0;
    $display("clear %s: busy for %0d cycles", tag, cnt);
    chk({tag, "_busyCycles"}, cnt, 240);
    chk({tag, "_validDuringClear"}, int'(sawValid), 0);
    chk({tag, "_validAfterClear"}, int'(summaryValid), 0);
    modelClear();
  endtask

  task automatic acceptSummary();
    summaryReady = 1'b1;
    @(negedge clk);
    summaryReady = 1'b0;
    $display("accept -> valid=%0d busy=%0d overrun=%0d", summaryValid, busy, overrun);
  endtask

  task automatic readAt(input int x, input int y, input int exp, input string name);
    readX = 8'(x);
    readY = 8'(y);
    @(negedge clk);
    $display("read x=%0d y=%0d -> %0d", x, y, readData);
    chk(name, int'(readData), exp);
  endtask

  initial begin
    int prevX = 0;
    int prevY = 0;

    reset = 1'b1;
    writeMedianMem = 1'b0; writeMedianData = 1'b0;
    xAddressOutMedianMem = '0; yAddressOutMedianMem = '0;
    fullImageDone = 1'b0; summaryReady = 1'b0;
    readX = '0; readY = '0;
    modelClear();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", int'(busy), 1);
    chk("rst_valid", int'(summaryValid), 0);
    chk("rst_count", int'(activeCount), 0);
    chk("rst_readData", int'(readData), 0);
    chk("rst_overrun", int'(overrun), 0);
    checkBox("rst");
    reset = 1'b0;
    waitClear("initial", 1'b0, 1'b0);

    // Table-driven writes, including a rewrite and a clear
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].x, vecs[i].y, vecs[i].d, 1'b0);
      modelWrite(vecs[i].x, vecs[i].y, vecs[i].d);
      chk("tbl_count", int'(activeCount), vecs[i].expCount);
    end
    chk("tbl_validBeforeDone", int'(summaryValid), 0);
    fullImageDone = 1'b1;
    @(negedge clk);
    fullImageDone = 1'b0;
    chk("tbl_validAfterDone", int'(summaryValid), 1);
    chk("tbl_summaryCount", int'(activeCount), refCount());
    checkBox("tbl");
    chk("tbl_overrun", int'(overrun), 0);

    // Summary held for 50 cycles. A write in REPORT is dropped.
    for (int c = 0; c < 50; c++) begin
      writeMedianMem       = (c == 10);
      writeMedianData      = 1'b0;
      xAddressOutMedianMem = 8'd11;
      yAddressOutMedianMem = 8'd21;
      readX = (c % 2 == 1) ? 8'd11 : 8'd10;
      readY = (c % 2 == 1) ? 8'd21 : 8'd20;
      @(negedge clk);
      chk("hold_valid", int'(summaryValid), 1);
      chk("hold_count", int'(activeCount), 1);
      chk("hold_read", int'(readData), int'(refMem[readX][readY]));
    end
    writeMedianMem = 1'b0;
    $display("hold done: valid=%0d count=%0d overrun=%0d", summaryValid, activeCount, overrun);
    checkBox("hold");
    chk("hold_overrun", int'(overrun), 1);
    readX = 8'd11; readY = 8'd21;
    acceptSummary();
    chk("acc_valid", int'(summaryValid), 0);
    chk("acc_busy", int'(busy), 1);
    chk("acc_read", int'(readData), 1);
    // A write landing in an already-cleared column during CLEAR must be dropped.
    waitClear("afterAccept", 1'b1, 1'b0);
    readAt(11, 21, 0, "cleared_read_11_21");
    readAt(0, 0, 0, "clearWrite_read_0_0");
    chk("clearWrite_overrun", int'(overrun), 1);
    chk("clearWrite_count", int'(activeCount), 0);

    // Out-of-range writes in COLLECT
    drive(240, 5, 1'b1, 1'b0);
    chk("oorX_count", int'(activeCount), 0);
    chk("oorX_overrun", int'(overrun), 1);
    drive(5, 180, 1'b1, 1'b0);
    chk("oorY_count", int'(activeCount), 0);
    readAt(5, 5, 0, "oor_read_5_5");

    // Randomized writes and reads against the reference model
    for (int t = 0; t < 300; t++) begin
      int x, y, rx, ry, expRd;
      bit d, doRd;
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) x = $urandom_range(240, 255);
      if ($urandom_range(0, 7) == 0) y = $urandom_range(180, 255);
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        rx = prevX; ry = prevY;
      end else begin
        rx = $urandom_range(0, 20); ry = $urandom_range(0, 20);
      end
      if ($urandom_range(0, 15) == 0) rx = $urandom_range(240, 255);
      doRd  = !(rx == x && ry == y);
      expRd = (rx < W && ry < H) ? int'(refMem[rx][ry]) : 0;
      readX = 8'(rx);
      readY = 8'(ry);
      drive(x, y, d, 1'b0);
      modelWrite(x, y, d);
      chk("rnd_count", int'(activeCount), refCount());
      if (doRd) chk("rnd_read", int'(readData), expRd);
      prevX = x; prevY = y;
    end

    // End of frame together with a write: the write counts
    drive(7, 9, 1'b1, 1'b1);
    modelWrite(7, 9, 1'b1);
    chk("rndEnd_valid", int'(summaryValid), 1);
    chk("rndEnd_count", int'(activeCount), refCount());
    checkBox("rndEnd");
    chk("rndEnd_overrun", int'(overrun), 1);
    acceptSummary();
    chk("rndAcc_overrunCleared", int'(overrun), 0);
    chk("rndAcc_valid", int'(summaryValid), 0);
    waitClear("afterRandom", 1'b0, 1'b0);

    // Empty frame: a write and the end-of-frame pulse arrive in the same cycle
    drive(5, 5, 1'b1, 1'b1);
    modelWrite(5, 5, 1'b1);
    chk("sameCycle_valid", int'(summaryValid), 1);
    chk("sameCycle_count", int'(activeCount), 1);
    checkBox("sameCycle");
    acceptSummary();
    waitClear("afterSameCycle", 1'b0, 1'b0);

    // Mid-frame reset with seven pixels set
    for (int i = 0; i < 7; i++) begin
      drive(i * 3, i * 2 + 1, 1'b1, 1'b0);
      modelWrite(i * 3, i * 2 + 1, 1'b1);
    end
    chk("midRst_countBefore", int'(activeCount), 7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelClear();
    chk("midRst_busy", int'(busy), 1);
    chk("midRst_count", int'(activeCount), 0);
    chk("midRst_valid", int'(summaryValid), 0);
    checkBox("midRst");
    // fullImageDone during CLEAR must be ignored
    waitClear("afterMidReset", 1'b0, 1'b1);
    for (int i = 0; i < 7; i++)
      readAt(i * 3, i * 2 + 1, 0, "midRst_read");
    readAt(240, 0, 0, "oorRead");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
